// File: rtl/fwd_ctrl.sv
// Forwarding / load-use hazard control for the 5-stage pipeline: registered EX operand select codes
// plus a combinational stall. Optional saturating stall counter when FWD_STALL_CNT_EN is defined.

// Select code for one EX operand; the newest live producer wins.
module fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic              en,
    input  logic [REG_AW-1:0] src,
    input  logic              s1_live,
    input  logic [REG_AW-1:0] s1_rd,
    input  logic              s2_live,
    input  logic [REG_AW-1:0] s2_rd,
    output logic [1:0]        code
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    always_comb begin
        code = SEL_RF;
        if (en && (src != '0)) begin
            if (s1_live && (s1_rd == src))
                code = SEL_MEM;
            else if (s2_live && (s2_rd == src))
                code = SEL_WB;
        end
    end
endmodule

module fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_uses_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_we,
    input  logic              dec_is_load,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } stage_rec_t;

    stage_rec_t s1, s2, s3;
    logic       s1_live, s2_live;

    logic [NUM_OPS-1:0][REG_AW-1:0] src;
    logic [NUM_OPS-1:0]             src_en;
    logic [NUM_OPS-1:0][1:0]        code_nxt;
    logic [NUM_OPS-1:0][1:0]        code_q;

    assign s1_live = s1.we && (s1.rd != '0);
    assign s2_live = s2.we && (s2.rd != '0);

    // Operand 0 is A (rs), operand 1 is B (rt, only when actually read).
    assign src[0]    = dec_rs;
    assign src[1]    = dec_rt;
    assign src_en[0] = dec_valid;
    assign src_en[1] = dec_valid && dec_uses_rt;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_sel #(.REG_AW(REG_AW)) u_sel (
            .en      (src_en[i]),
            .src     (src[i]),
            .s1_live (s1_live),
            .s1_rd   (s1.rd),
            .s2_live (s2_live),
            .s2_rd   (s2.rd),
            .code    (code_nxt[i])
        );
    end

    // A load in ID/EX cannot forward in time; a taken branch squashes the consumer anyway.
    always_comb begin
        stall = 1'b0;
        if (!flush && dec_valid && s1_live && s1.ld)
            stall = (dec_rs == s1.rd) || (dec_uses_rt && (dec_rt == s1.rd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            code_q <= '0;
        end else if (!hold) begin
            s3 <= s2;
            s2 <= s1;
            if (flush || stall) begin
                s1     <= '0;
                code_q <= '0;
            end else begin
                s1     <= '{rd: dec_rd, we: dec_we && dec_valid, ld: dec_is_load && dec_valid};
                code_q <= code_nxt;
            end
        end
    end

    assign fwd_a = code_q[0];
    assign fwd_b = code_q[1];

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!hold && stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed self-checking bench for fwd_ctrl; covers the stall counter when FWD_STALL_CNT_EN is defined.
module tb_fwd_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hold = 1'b0;
    logic              flush = 1'b0;
    logic              dec_valid = 1'b0;
    logic [REG_AW-1:0] dec_rs = '0;
    logic [REG_AW-1:0] dec_rt = '0;
    logic              dec_uses_rt = 1'b0;
    logic [REG_AW-1:0] dec_rd = '0;
    logic              dec_we = 1'b0;
    logic              dec_is_load = 1'b0;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall;
`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .dec_uses_rt (dec_uses_rt),
        .dec_rd      (dec_rd),
        .dec_we      (dec_we),
        .dec_is_load (dec_is_load),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urt, input logic [4:0] rd, input logic we, input logic ld);
        dec_valid = v; dec_rs = rs; dec_rt = rt; dec_uses_rt = urt;
        dec_rd = rd; dec_we = we; dec_is_load = ld;
        #1;
    endtask

    task automatic do_reset();
        hold = 1'b0; flush = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_init got a=%b b=%b stall=%b exp 00 00 0", fwd_a, fwd_b, stall);
        end
        set_dec(1, 0, 0, 0, 3, 1, 0); step();
        set_dec(1, 3, 0, 0, 7, 1, 1); step();
        n_checks++;
        if (fwd_a !== 2'b01) begin
            n_fail++; $display("FAIL reset_pre_a got %b exp 01", fwd_a);
        end
        set_dec(1, 7, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_stall got %b exp 1", stall);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_async got a=%b b=%b stall=%b exp 00 00 0", fwd_a, fwd_b, stall);
        end
`ifdef FWD_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_dec(1, 7, 0, 0, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b00) begin
            n_fail++; $display("FAIL reset_after got %b exp 00", fwd_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_dec(1, 0, 0, 0, 3, 1, 0); step();
        set_dec(1, 3, 3, 1, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            n_fail++; $display("FAIL b2b got a=%b b=%b exp 01 01", fwd_a, fwd_b);
        end
        do_reset();
        set_dec(1, 0, 0, 0, 3, 1, 0); step();
        set_dec(0, 3, 3, 1, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_fail++; $display("FAIL b2b_invalid got a=%b b=%b exp 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_distance2();
        do_reset();
        set_dec(1, 0, 0, 0, 5, 1, 0); step();
        set_dec(1, 1, 2, 1, 9, 1, 0); step();
        set_dec(1, 5, 9, 1, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
            n_fail++; $display("FAIL dist2 got a=%b b=%b exp 10 01", fwd_a, fwd_b);
        end
        do_reset();
        set_dec(1, 0, 0, 0, 5, 1, 0); step();
        set_dec(1, 1, 0, 0, 5, 1, 0); step();
        set_dec(1, 5, 0, 0, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b01) begin
            n_fail++; $display("FAIL dist2_override got %b exp 01", fwd_a);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1, 0, 0, 0, 7, 1, 1); step();
        set_dec(1, 7, 0, 0, 8, 1, 0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall got %b exp 1", stall);
        end
        step();
        n_checks++;
        if (fwd_a !== 2'b00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_bubble got a=%b stall=%b exp 00 0", fwd_a, stall);
        end
        step();
        n_checks++;
        if (fwd_a !== 2'b10) begin
            n_fail++; $display("FAIL lu_fwd got %b exp 10", fwd_a);
        end
`ifdef FWD_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt);
        end
`endif
        do_reset();
        set_dec(1, 0, 0, 0, 7, 1, 1); step();
        set_dec(1, 2, 7, 0, 0, 0, 0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_no_rt got %b exp 0", stall);
        end
        set_dec(1, 2, 7, 1, 0, 0, 0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_rt got %b exp 1", stall);
        end
    endtask

    task automatic test_zero_and_no_rt();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 1, 0); step();
        set_dec(1, 0, 0, 1, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_fail++; $display("FAIL zero_reg got a=%b b=%b exp 00 00", fwd_a, fwd_b);
        end
        do_reset();
        set_dec(1, 0, 0, 0, 3, 1, 0); step();
        set_dec(1, 1, 3, 0, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_fail++; $display("FAIL no_rt got a=%b b=%b exp 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_dec(1, 0, 0, 0, 7, 1, 1); step();
        set_dec(1, 7, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall got %b exp 0", stall);
        end
        step();
        flush = 1'b0;
        #1;
        n_checks++;
        if (fwd_a !== 2'b00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_bubble got a=%b stall=%b exp 00 0", fwd_a, stall);
        end
`ifdef FWD_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL flush_cnt got %0d exp 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_hold();
        do_reset();
        set_dec(1, 0, 0, 0, 4, 1, 0); step();
        set_dec(1, 4, 0, 0, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b01) begin
            n_fail++; $display("FAIL hold_pre got %b exp 01", fwd_a);
        end
        hold = 1'b1;
        set_dec(1, 9, 9, 1, 6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
                n_fail++; $display("FAIL hold_cyc%0d got a=%b b=%b exp 01 00", i, fwd_a, fwd_b);
            end
        end
        hold = 1'b0;
        set_dec(1, 4, 0, 0, 0, 0, 0); step();
        n_checks++;
        if (fwd_a !== 2'b10) begin
            n_fail++; $display("FAIL hold_records got %b exp 10", fwd_a);
        end
        do_reset();
        set_dec(1, 0, 0, 0, 7, 1, 1); step();
        hold = 1'b1;
        set_dec(1, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL hold_stall got %b exp 1", stall);
        end
`ifdef FWD_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL hold_cnt got %0d exp 0", stall_cnt);
        end
`endif
        hold = 1'b0;
        step();
        n_checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00) begin
            n_fail++; $display("FAIL hold_release got stall=%b a=%b exp 0 00", stall, fwd_a);
        end
`ifdef FWD_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL hold_cnt_after got %0d exp 1", stall_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_zero_and_no_rt();
        test_flush_priority();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding/hazard control unit for the 5-stage pipeline; generates the 2-bit select codes that drive the EX-stage 3-way operand selectors: 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result; 11 is never driven.
- Tracks destination register, write-enable and load flag of in-flight instructions in ID/EX, EX/MEM and MEM/WB.
- Raises a load-use stall.
- Sits beside the decode stage; select codes are registered, so they are valid during the cycle the instruction occupies EX.

Parameters:
REG_AW, 5, register-index width (32 architectural registers; register 0 is hardwired zero).
CNT_W, 16, width of the optional stall counter.

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
hold  input  1  global freeze (memory wait); all state holds.
flush  input  1  branch/jump taken; the decode instruction is squashed.
dec_valid  input  1  decode stage holds a real instruction.
dec_rs  input  REG_AW  source A index.
dec_rt  input  REG_AW  source B index.
dec_uses_rt  input  1  instruction reads rt as an operand.
dec_rd  input  REG_AW  destination index.
dec_we  input  1  instruction writes dec_rd.
dec_is_load  input  1  instruction is a memory load.
fwd_a  output  2  select code for EX operand A.
fwd_b  output  2  select code for EX operand B.
stall  output  1  hold PC and IF/ID; a bubble enters ID/EX.

Behaviour:
- Internal stage records S1 (ID/EX), S2 (EX/MEM), S3 (MEM/WB) = {rd, we, ld}.
  - A record is "live" when we = 1 and rd != 0.
- Reset (rst_n low, asynchronous): all records cleared (we = 0, ld = 0, rd = 0); fwd_a = fwd_b = 2'b00; stall low.
- stall is combinational and equals dec_valid & S1 live & S1.ld & (dec_rs == S1.rd | (dec_uses_rt & dec_rt == S1.rd)).
  - stall is forced low while flush = 1.
- Per rising edge, in priority order:
  - hold = 1: every register keeps its value, fwd_a and fwd_b included. stall stays combinationally valid.
  - flush = 1: S1 <= bubble (we = 0), fwd_a/fwd_b <= 00, S3 <= S2, S2 <= S1.
  - stall = 1: same as flush (bubble into S1, codes 00, S3 <= S2, S2 <= S1).
  - Otherwise: S3 <= S2, S2 <= S1, and S1 <= {dec_rd, dec_we & dec_valid, dec_is_load & dec_valid}.
    - fwd_a <= 01 if S1 live and S1.rd == dec_rs; else 10 if S2 live and S2.rd == dec_rs; else 00.
    - fwd_b: same rule using dec_rt, and forced to 00 when dec_uses_rt = 0.
    - When dec_valid = 0, both codes <= 00.
- Newest producer wins: when S1 and S2 both match, the code is 01.
- A load in S1 never produces 01; the stall prevents it. After the one-cycle stall the load sits in S2, so the code is 10.
- Source index 0 always yields 00.
- Latency: codes appear one cycle after the decode sample. stall has zero latency.
- Reset asserted mid-stall or mid-hold clears everything immediately. The first edge after release behaves as an empty pipeline.

Optional Feature:
FWD_STALL_CNT_EN:
- Defined: adds output stall_cnt [CNT_W-1:0].
  - Resets to 0.
  - Increments on each edge where stall = 1 and hold = 0.
  - Saturates at all-ones.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-operation -> fwd_a = fwd_b = 00, stall = 0, all records cleared asynchronously.
- Back-to-back ALU: cycle 0 dec rd = 3, we = 1; cycle 1 dec rs = 3, rt = 3, uses_rt = 1 -> after edge 2, fwd_a = 01, fwd_b = 01.
- Distance-2 with override:
  - rd = 5 at cycle 0, an unrelated instruction at cycle 1, rs = 5 at cycle 2 -> fwd_a = 10.
  - If the cycle-1 instruction also writes rd = 5 -> fwd_a = 01.
- Load-use: load rd = 7 followed by rs = 7 -> stall = 1 for exactly one cycle, bubble codes 00, then fwd_a = 10. With FWD_STALL_CNT_EN defined, stall_cnt = 1.
- Register zero and no rt: rd = 0, we = 1, then rs = 0, rt = 0 -> codes 00. With rt = 3 matching S1 but uses_rt = 0 -> fwd_b = 00.
- Priority:
  - flush and a load-use match in the same cycle -> stall = 0 and a bubble is inserted.
  - hold = 1 for 3 cycles -> fwd_a and records unchanged; stall_cnt not incremented.
